// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants: instruction kinds, opcodes, ALU control codes
// and funct fields, used by both the program loader and the ALU decoder.
package rv_pkg;

    typedef enum logic [2:0] {
        KIND_R   = 3'd0,
        KIND_I   = 3'd1,
        KIND_LW  = 3'd2,
        KIND_SW  = 3'd3,
        KIND_BEQ = 3'd4,
        KIND_JAL = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } enc_state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU control codes as the single-cycle controller produces them
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_ZERO = 7'b0000000;

    function automatic logic [2:0] alu_funct3(input logic [2:0] aluctl);
        case (aluctl)
            ALU_AND: return F3_AND;
            ALU_OR:  return F3_OR;
            ALU_SLT: return F3_SLT;
            default: return F3_ADD;
        endcase
    endfunction

    // True when v is representable as a signed value of the given bit count
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic signed [31:0] s;
        s = $signed(v) >>> (bits - 1);
        return (s == 32'sd0) || (s == -32'sd1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-beat stream into the encoder plus the instruction-memory write port.
interface instr_encoder_if #(parameter int AW = 8);
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [2:0]    kind;
    logic [2:0]    aluctl;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [31:0]   imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic          imem_ready;

    modport master (
        output in_valid, in_last, kind, aluctl, rd, rs1, rs2, imm, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wd
    );

    modport slave (
        input  in_valid, in_last, kind, aluctl, rd, rs1, rs2, imm, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wd
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields to a 32-bit RV32I word plus a legality flag.
module instr_pack
    import rv_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  aluctl,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic r_ok;
    logic i_ok;
    logic [2:0] f3;

    assign r_ok = aluctl inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
    assign i_ok = aluctl inside {ALU_ADD, ALU_AND, ALU_OR, ALU_SLT};
    assign f3   = alu_funct3(aluctl);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (kind)
            KIND_R: begin
                legal = r_ok;
                word  = {(aluctl == ALU_SUB) ? F7_SUB : F7_ZERO, rs2, rs1, f3, rd, OP_R};
            end
            KIND_I: begin
                legal = i_ok && fits_signed(imm, 12);
                word  = {imm[11:0], rs1, f3, rd, OP_I};
            end
            KIND_LW: begin
                legal = fits_signed(imm, 12);
                word  = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
            end
            KIND_SW: begin
                legal = fits_signed(imm, 12);
                word  = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
            end
            // Branch and jump offsets are halfword-aligned, so bit 0 is never encoded
            KIND_BEQ: begin
                legal = fits_signed(imm, 13) && !imm[0];
                word  = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
            end
            KIND_JAL: begin
                legal = fits_signed(imm, 21) && !imm[0];
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts field beats, encodes them and streams the words into
// instruction memory from a base address through a one-entry output register.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    instr_encoder_if.slave bus,
    output logic          done,
    output logic [AW:0]   count,
    output logic          err,
    output logic          ovf
);

    enc_state_e state, state_nxt;

    logic [AW-1:0] ptr;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          we;
    logic [31:0]   word;
    logic          legal;
    logic          in_ready;
    logic          accept;
    logic          drained;
    logic          full;

    instr_pack u_pack (
        .kind   (bus.kind),
        .aluctl (bus.aluctl),
        .rd     (bus.rd),
        .rs1    (bus.rs1),
        .rs2    (bus.rs2),
        .imm    (bus.imm),
        .word   (word),
        .legal  (legal)
    );

    // count can never exceed DEPTH, so its top bit alone means capacity reached
    assign full    = count[AW];
    assign drained = we & bus.imem_ready;
    assign accept  = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.imem_we   = we;
    assign bus.imem_addr = addr;
    assign bus.imem_wd   = wd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                in_ready = full | !we | bus.imem_ready;
                if (accept && bus.in_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (!we || drained) state_nxt = ST_DONE;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A new accept on the same edge as a drain overwrites the drained word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            addr  <= '0;
            wd    <= '0;
            we    <= 1'b0;
            count <= '0;
            err   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (drained) we <= 1'b0;
            if (state == ST_IDLE && start) begin
                ptr   <= base;
                count <= '0;
                err   <= 1'b0;
                ovf   <= 1'b0;
            end
            if (accept) begin
                if (full) begin
                    ovf <= 1'b1;
                end else if (legal) begin
                    we    <= 1'b1;
                    addr  <= ptr;
                    wd    <= word;
                    ptr   <= ptr + 1'b1;
                    count <= count + 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and program loader: the encoding counterpart of the single-cycle controller's decode. Accepts decoded instruction fields (instruction kind, ALU control code as the controller produces it, register numbers, immediate) over a valid/ready stream. It packs them into 32-bit instruction words and writes them into instruction memory from a programmable base word address. Used by the self-test and boot path to build programs in place.

## Interface
- AW, 8, instruction-memory word-address width; capacity DEPTH = 2**AW words
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  pulse; in IDLE, loads base and begins a load session
- base  in  AW  first word address of the session
- in_valid  in  1  field beat valid
- in_ready  out  1  beat accepted on clk edge when in_valid & in_ready
- in_last  in  1  final beat of session
- kind  in  3  0 R-ALU, 1 I-ALU, 2 lw, 3 sw, 4 beq, 5 jal, 6/7 illegal
- aluctl  in  3  controller ALU code: 000 add, 001 sub, 010 and, 011 or, 101 slt
- rd, rs1, rs2  in  5 each  register numbers; unused fields ignored
- imm  in  32  signed immediate / byte offset
- imem_we  out  1  write strobe, held until imem_ready
- imem_addr  out  AW  word address
- imem_wd  out  32  instruction word
- imem_ready  in  1  memory accepts write this cycle
- done  out  1  one-cycle pulse at end of session
- count  out  AW+1  words written this session, valid with done and after
- err  out  1  sticky; cleared by start
- ovf  out  1  sticky capacity overflow; cleared by start

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: in_ready=0. start → LOAD; addr←base, count←0, err←0, ovf←0.
- LOAD: in_ready = !imem_we | imem_ready (1-entry output register, pass-through when draining).
- Accepted beat with legal fields: encode into output register, imem_we←1, addr and count increment. addr wraps mod DEPTH.
- Accepted beat with illegal fields: err←1, no write, no address/count change.
- Illegal fields are:
  - kind 6/7.
  - R-ALU aluctl ∉ {000,001,010,011,101}.
  - I-ALU aluctl ∉ {000,010,011,101}.
  - I/S imm outside −2048..2047.
  - beq imm outside −4096..4094 or imm[0]=1.
  - jal imm outside −1048576..1048574 or imm[0]=1.
- Accepted beat with in_last → DRAIN, illegal or not.
- When count reaches DEPTH, further beats are dropped: in_ready held 1, ovf←1, no write. in_last still ends the session.
- DRAIN: in_ready=0; wait until !imem_we, or imem_ready with the final word, → DONE.
- DONE: done=1 for one cycle → IDLE. count holds until next start.
- start outside IDLE is ignored.
- Field mapping:
  - R: op 0110011; funct3 add/sub 000, and 111, or 110, slt 010; funct7 0100000 for sub, else 0.
  - I-ALU: op 0010011, same funct3 map.
  - lw: op 0000011, f3 010, I-imm.
  - sw: op 0100011, f3 010, S-imm.
  - beq: op 1100011, f3 000, B-imm.
  - jal: op 1101111, J-imm.

## Timing
- Reset values: state IDLE; in_ready, imem_we, done, err, ovf, count, imem_addr, imem_wd all 0.
- Latency: beat accepted at edge N → imem_we/addr/wd valid cycle N+1. Sustained 1 word/cycle while imem_ready=1.
- imem_ready=0: output register holds stable, in_ready=0, no beat lost.
- Simultaneous imem_ready and new accept: new word replaces drained word same edge.
- Reset mid-session: pending word discarded, no partial write.
- Reset mid-session: done never pulses.

## Structure
- Shared package rv_pkg holds:
  - kind enum.
  - opcode constants.
  - ALU-control codes, shared with the ALU decoder so encode/decode match.
  - funct3/funct7 constants.
- One sub-module instr_pack: combinational fields → word + legal flag. The FSM, output register and counters live in instr_encoder.

## Test plan
- start, base=0x10; beat I-ALU aluctl=000 rd=5 rs1=0 imm=7, last → one write addr 0x10 data 0x00700293; done, count=1.
- R sub rd=3 rs1=1 rs2=2; sw rs1=2 rs2=6 imm=8; beq rs1=rs2=0 imm=−4; jal rd=1 imm=2048 back-to-back, imem_ready=1 → 0x402081B3, 0x00612423, 0xFE000EE3, 0x001000EF on consecutive cycles.
- imem_ready low 3 cycles mid-stream → imem_wd stable, in_ready=0, no loss or duplicate.
- beq imm=3, then I-ALU aluctl=001 → err=1, no writes, count=0, next legal word at base.
- AW=2, base=3, 5 beats → addresses 3,0,1,2 written; 5th dropped; ovf=1; count=4.
- Reset asserted with imem_we pending → outputs 0 immediately; no write; new start works.
